// File: rtl/clb_router_pkg.sv
// clb_router_pkg: shared loader state encoding and identity-config helper
// for the clb_chain_router slice.
package clb_router_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK,
    COMMIT
  } ld_state_t;

  localparam int MAX_CFG_W = 1024;

  // sel[i] = i packed CLB0-first, SEL_W bits per field
  function automatic logic [MAX_CFG_W-1:0] identity_cfg(
    input int n_clb,
    input int sel_w
  );
    logic [MAX_CFG_W-1:0] cfg;
    cfg = '0;
    for (int i = 0; i < n_clb; i++)
      cfg = cfg | (MAX_CFG_W'(i) << (i * sel_w));
    return cfg;
  endfunction

endpackage

// File: rtl/clb_chain_router_loader.sv
// clb_cfg_loader: serial config loader with permutation check.
// With CFG_PARITY_EN a trailing even-parity bit is appended and checked.
module clb_cfg_loader
  import clb_router_pkg::*;
#(
  parameter int N_CLB = 4,
  localparam int SEL_W = $clog2(N_CLB),
  localparam int CFG_W = N_CLB * SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_bit,
  input  logic             cfg_bit_valid,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic             commit,
  output logic [CFG_W-1:0] shadow_cfg
);

`ifdef CFG_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int TOT_W = CFG_W + PAR_W;
  localparam int CNT_W = $clog2(TOT_W + 1);

  ld_state_t        state_q, state_d;
  logic [TOT_W-1:0] shadow_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last;
  logic             range_ok;
  logic             par_ok;
  logic             ok;
  logic [N_CLB-1:0] seen;
  logic [SEL_W-1:0] fld;
  int               idx;

  assign last       = cnt_q == CNT_W'(TOT_W - 1);
  assign commit     = state_q == COMMIT;
  assign shadow_cfg = shadow_q[CFG_W-1:0];

  // Permutation: all fields in range and every slice index seen
  always_comb begin
    seen     = '0;
    range_ok = 1'b1;
    fld      = '0;
    idx      = 0;
    for (int i = 0; i < N_CLB; i++) begin
      fld = shadow_q[i*SEL_W +: SEL_W];
      idx = int'(fld);
      if (idx < N_CLB) seen[fld] = 1'b1;
      else range_ok = 1'b0;
    end
`ifdef CFG_PARITY_EN
    par_ok = ~^shadow_q;
`else
    par_ok = 1'b1;
`endif
    ok = range_ok & (&seen) & par_ok;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cfg_start) state_d = SHIFT;
      SHIFT:   if (cfg_bit_valid && last) state_d = CHECK;
      CHECK:   state_d = ok ? COMMIT : IDLE;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      cnt_q    <= '0;
      cfg_busy <= 1'b0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_busy <= state_d != IDLE;
      cfg_done <= state_q == COMMIT;
      if (state_q == IDLE && cfg_start) begin
        cnt_q   <= '0;
        cfg_err <= 1'b0;
      end
      if (state_q == SHIFT && cfg_bit_valid) begin
        cnt_q    <= cnt_q + CNT_W'(1);
        shadow_q <= {cfg_bit, shadow_q[TOT_W-1:1]};
      end
      if (state_q == CHECK && !ok) cfg_err <= 1'b1;
    end
  end

endmodule

// File: rtl/clb_chain_router.sv
// clb_chain_router: routes operand slices and carries through a runtime
// CLB permutation; CFG_PARITY_EN adds a parity bit to the config stream.
module clb_chain_router
  import clb_router_pkg::*;
#(
  parameter int N_CLB = 4,
  parameter int SLICE_W = 2,
  localparam int SEL_W = $clog2(N_CLB),
  localparam int DW = N_CLB * SLICE_W,
  localparam int CFG_W = N_CLB * SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_bit,
  input  logic             cfg_bit_valid,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err,
  input  logic [DW-1:0]    op_a,
  input  logic [DW-1:0]    op_b,
  input  logic             c_ext,
  input  logic             in_valid,
  output logic [DW-1:0]    clb_in_a,
  output logic [DW-1:0]    clb_in_b,
  output logic [N_CLB-1:0] clb_cin,
  input  logic [DW-1:0]    clb_sum,
  input  logic [N_CLB-1:0] clb_cout,
  output logic [DW-1:0]    sum_out,
  output logic             cout_out,
  output logic             out_valid
);

  localparam logic [CFG_W-1:0] ID_CFG =
    CFG_W'(identity_cfg(N_CLB, SEL_W));

  logic             commit;
  logic [CFG_W-1:0] shadow_cfg;
  logic [CFG_W-1:0] active_q;
  logic [SEL_W-1:0] sel [N_CLB];
  logic [SEL_W-1:0] pos [N_CLB];
  logic [DW-1:0]    sum_d;
  logic             cout_d;

  clb_cfg_loader #(
    .N_CLB(N_CLB)
  ) u_loader (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_start    (cfg_start),
    .cfg_bit      (cfg_bit),
    .cfg_bit_valid(cfg_bit_valid),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .commit       (commit),
    .shadow_cfg   (shadow_cfg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) active_q <= ID_CFG;
    else if (commit) active_q <= shadow_cfg;
  end

  // pos is the inverse permutation: CLB handling slice j
  always_comb begin
    for (int i = 0; i < N_CLB; i++)
      sel[i] = active_q[i*SEL_W +: SEL_W];
    for (int j = 0; j < N_CLB; j++)
      pos[j] = '0;
    for (int i = 0; i < N_CLB; i++)
      pos[sel[i]] = SEL_W'(i);
  end

  always_comb begin
    clb_in_a = '0;
    clb_in_b = '0;
    clb_cin  = '0;
    for (int i = 0; i < N_CLB; i++) begin
      clb_in_a[i*SLICE_W +: SLICE_W] =
        op_a[sel[i]*SLICE_W +: SLICE_W];
      clb_in_b[i*SLICE_W +: SLICE_W] =
        op_b[sel[i]*SLICE_W +: SLICE_W];
      clb_cin[i] = (sel[i] == '0) ? c_ext :
        clb_cout[pos[sel[i] - SEL_W'(1)]];
    end
  end

  always_comb begin
    sum_d = '0;
    for (int j = 0; j < N_CLB; j++)
      sum_d[j*SLICE_W +: SLICE_W] =
        clb_sum[pos[j]*SLICE_W +: SLICE_W];
    cout_d = clb_cout[pos[N_CLB-1]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_out   <= '0;
      cout_out  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_out  <= sum_d;
        cout_out <= cout_d;
      end
    end
  end

endmodule

// File: tb/tb_clb_chain_router.sv
// tb_clb_chain_router: random operands and config loads against a
// behavioural model of a permuted ripple-carry adder built from CLBs.
module tb_clb_chain_router;

  localparam int N     = 4;
  localparam int W     = 2;
  localparam int SEL_W = 2;
  localparam int CFG_W = N * SEL_W;
  localparam int DW    = N * W;
`ifdef CFG_PARITY_EN
  localparam int TW = CFG_W + 1;
`else
  localparam int TW = CFG_W;
`endif

  logic          clk;
  logic          rst_n;
  logic          cfg_start;
  logic          cfg_bit;
  logic          cfg_bit_valid;
  logic          cfg_busy;
  logic          cfg_done;
  logic          cfg_err;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          c_ext;
  logic          in_valid;
  logic [DW-1:0] clb_in_a;
  logic [DW-1:0] clb_in_b;
  logic [N-1:0]  clb_cin;
  logic [DW-1:0] clb_sum;
  logic [N-1:0]  clb_cout;
  logic [DW-1:0] sum_out;
  logic          cout_out;
  logic          out_valid;

  int n_chk = 0;
  int n_err = 0;
  int busy_n;
  int done_n;
  bit rand_ops;
  logic [CFG_W-1:0] sel_m, pend_sel, id_cfg;
  logic [DW-1:0] e_sum;
  logic e_cout, e_valid;

  clb_chain_router #(
    .N_CLB  (N),
    .SLICE_W(W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_start    (cfg_start),
    .cfg_bit      (cfg_bit),
    .cfg_bit_valid(cfg_bit_valid),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .op_a         (op_a),
    .op_b         (op_b),
    .c_ext        (c_ext),
    .in_valid     (in_valid),
    .clb_in_a     (clb_in_a),
    .clb_in_b     (clb_in_b),
    .clb_cin      (clb_cin),
    .clb_sum      (clb_sum),
    .clb_cout     (clb_cout),
    .sum_out      (sum_out),
    .cout_out     (cout_out),
    .out_valid    (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // External CLB array: plain slice adders, re-evaluated every 1ns
  initial begin
    int r;
    clb_sum  = '0;
    clb_cout = '0;
    forever begin
      #1;
      for (int i = 0; i < N; i++) begin
        r = int'(clb_in_a[i*W +: W]) + int'(clb_in_b[i*W +: W])
          + int'(clb_cin[i]);
        clb_sum[i*W +: W] = W'(r);
        clb_cout[i] = r[W];
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int fld(input logic [CFG_W-1:0] w, input int i);
    return int'(w[i*SEL_W +: SEL_W]);
  endfunction

  function automatic bit perm_ok(input logic [CFG_W-1:0] w);
    int cnt [N];
    int f;
    foreach (cnt[k]) cnt[k] = 0;
    for (int i = 0; i < N; i++) begin
      f = fld(w, i);
      if (f >= N) return 1'b0;
      cnt[f]++;
    end
    foreach (cnt[k]) if (cnt[k] != 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [TW-1:0] mk_bits(input logic [CFG_W-1:0] w);
`ifdef CFG_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction

  function automatic logic [CFG_W-1:0] rand_perm();
    int p [N];
    int j, t;
    logic [CFG_W-1:0] w;
    for (int i = 0; i < N; i++) p[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    w = '0;
    for (int i = 0; i < N; i++) w[i*SEL_W +: SEL_W] = SEL_W'(p[i]);
    return w;
  endfunction

  // Carry into slice j of the full-width addition
  function automatic logic carry_into(input int j);
    longint m, s;
    m = (longint'(1) << (j * W)) - 1;
    s = (longint'(op_a) & m) + (longint'(op_b) & m) + longint'(c_ext);
    return s[j*W];
  endfunction

  task automatic check_route();
    logic [DW-1:0] ea, eb;
    logic [N-1:0] ec;
    int j;
    for (int i = 0; i < N; i++) begin
      j = fld(sel_m, i);
      ea[i*W +: W] = op_a[j*W +: W];
      eb[i*W +: W] = op_b[j*W +: W];
      ec[i] = carry_into(j);
    end
    chk("clb_in_a", 64'(clb_in_a), 64'(ea));
    chk("clb_in_b", 64'(clb_in_b), 64'(eb));
    chk("clb_cin", 64'(clb_cin), 64'(ec));
  endtask

  // One clock: entered and left at negedge, inputs already driven
  task automatic cyc();
    logic [DW:0] s;
    if (rand_ops) begin
      op_a     = DW'($urandom);
      op_b     = DW'($urandom);
      c_ext    = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
    end
    #8;
    if (rst_n) check_route();
    if (!rst_n) begin
      e_valid = 1'b0;
      e_sum   = '0;
      e_cout  = 1'b0;
    end else if (in_valid) begin
      s = (DW+1)'(op_a) + (DW+1)'(op_b) + (DW+1)'(c_ext);
      e_sum   = s[DW-1:0];
      e_cout  = s[DW];
      e_valid = 1'b1;
    end else begin
      e_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    if (!rst_n) sel_m = id_cfg;
    chk("out_valid", 64'(out_valid), 64'(e_valid));
    chk("sum_out", 64'(sum_out), 64'(e_sum));
    chk("cout_out", 64'(cout_out), 64'(e_cout));
    if (cfg_busy) busy_n++;
    if (cfg_done) begin
      done_n++;
      sel_m = pend_sel;
    end
    @(negedge clk);
  endtask

  task automatic load_cfg(input logic [TW-1:0] bits, input int gap0,
                          input int gap_at, input int gap_len);
    bit exp_ok;
    exp_ok = perm_ok(bits[CFG_W-1:0]);
`ifdef CFG_PARITY_EN
    if (^bits) exp_ok = 1'b0;
`endif
    busy_n = 0;
    done_n = 0;
    cfg_start = 1'b1;
    cfg_bit_valid = 1'b0;
    cyc();
    cfg_start = 1'b0;
    chk("err_cleared", 64'(cfg_err), 64'(0));
    repeat (gap0) cyc();
    for (int k = 0; k < TW; k++) begin
      if (k == gap_at) begin
        repeat (gap_len) begin
          cfg_bit_valid = 1'b0;
          cfg_start = 1'b1;
          cfg_bit = ~bits[k];
          cyc();
        end
        cfg_start = 1'b0;
      end
      cfg_bit = bits[k];
      cfg_bit_valid = 1'b1;
      if (k == TW - 1) pend_sel = exp_ok ? bits[CFG_W-1:0] : sel_m;
      cyc();
    end
    cfg_bit_valid = 1'b0;
    repeat (3) cyc();
    chk("busy_cycles", 64'(busy_n),
        64'(gap0 + gap_len + TW + (exp_ok ? 2 : 1)));
    chk("done_pulses", 64'(done_n), 64'(exp_ok ? 1 : 0));
    chk("cfg_err", 64'(cfg_err), 64'(!exp_ok));
    chk("busy_idle", 64'(cfg_busy), 64'(0));
  endtask

  initial begin
    logic [TW-1:0] b;
    logic [CFG_W-1:0] w;
    rst_n = 1'b0;
    cfg_start = 1'b0;
    cfg_bit = 1'b0;
    cfg_bit_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    c_ext = 1'b0;
    in_valid = 1'b0;
    rand_ops = 1'b0;
    for (int i = 0; i < N; i++) id_cfg[i*SEL_W +: SEL_W] = SEL_W'(i);
    sel_m = id_cfg;
    pend_sel = id_cfg;
    e_sum = '0;
    e_cout = 1'b0;
    e_valid = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    chk("rst_busy", 64'(cfg_busy), 64'(0));
    chk("rst_done", 64'(cfg_done), 64'(0));
    chk("rst_err", 64'(cfg_err), 64'(0));
    chk("rst_sum", 64'(sum_out), 64'(0));
    chk("rst_cout", 64'(cout_out), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));

    op_a = 8'hFF; op_b = 8'h01; c_ext = 1'b0; in_valid = 1'b1;
    cyc();
    chk("ff_plus_1_sum", 64'(sum_out), 64'(8'h00));
    chk("ff_plus_1_cout", 64'(cout_out), 64'(1));
    in_valid = 1'b0;
    op_a = 8'h12;
    cyc();
    chk("hold_sum", 64'(sum_out), 64'(8'h00));

    rand_ops = 1'b1;
    repeat (20) cyc();

    load_cfg(mk_bits(8'h1B), 1, TW, 0);
`ifndef CFG_PARITY_EN
    chk("busy_11", 64'(busy_n), 64'(11));
`endif
    rand_ops = 1'b0;
    op_a = 8'hFF; op_b = 8'h01; c_ext = 1'b0; in_valid = 1'b1;
    cyc();
    chk("rev_sum", 64'(sum_out), 64'(8'h00));
    chk("rev_cout", 64'(cout_out), 64'(1));
    chk("clb3_a", 64'(clb_in_a[7:6]), 64'(op_a[1:0]));
    c_ext = 1'b1;
    cyc();
    chk("clb3_cin", 64'(clb_cin[3]), 64'(1));
    rand_ops = 1'b1;
    repeat (10) cyc();

    load_cfg(mk_bits(8'h00), 0, TW, 0);
    repeat (5) cyc();

    load_cfg(mk_bits(8'hB1), 0, 4, 3);
    repeat (5) cyc();

`ifdef CFG_PARITY_EN
    load_cfg(TW'({1'b0, 8'hE4}), 0, TW, 0);
    repeat (3) cyc();
    load_cfg(TW'({1'b1, 8'hE4}), 0, TW, 0);
    repeat (3) cyc();
    load_cfg(mk_bits(8'hB1), 0, TW, 0);
`endif

    // Reset part-way through a load restores identity routing
    b = mk_bits(8'h1B);
    cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cfg_bit = b[k];
      cfg_bit_valid = 1'b1;
      cyc();
    end
    cfg_bit_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("midrst_busy", 64'(cfg_busy), 64'(0));
    chk("midrst_valid", 64'(out_valid), 64'(0));
    chk("midrst_done", 64'(cfg_done), 64'(0));
    repeat (10) cyc();

    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 2) != 0) w = rand_perm();
      else w = CFG_W'($urandom);
      b = mk_bits(w);
`ifdef CFG_PARITY_EN
      if ($urandom_range(0, 3) == 0) b[TW-1] = ~b[TW-1];
`endif
      load_cfg(b, $urandom_range(0, 2), $urandom_range(0, TW - 1),
               $urandom_range(0, 3));
      repeat (6) cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
